// File: rtl/bus_host_arb.sv
// bus_host_arb: round-robin arbiter that multiplexes NrHosts request ports onto one
// downstream bus host port and routes in-order responses back to the requester.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   host_*_i                per-host request (req, we, addr, be, wdata)
//   host_gnt_o              per-host grant, same cycle as the bus handshake
//   host_rvalid_o/err_o/rdata_o  per-host response, steered from the tracking FIFO head
//   bus_*_o / bus_*_i       shared downstream request and response channel
//   unexp_rsp_o             sticky: a response arrived with nothing outstanding
//   grant_cnt_o             per-host saturating handshake counters (BUS_ARB_PERF_EN only)
//
// Optional feature macro: BUS_ARB_PERF_EN adds grant_cnt_o and its counters.
module bus_host_arb #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NrHosts-1:0]                       host_req_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0][3:0]                  host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0]                       host_err_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic                                     bus_req_o,
    output logic                                     bus_we_o,
    output logic [AddressWidth-1:0]                  bus_addr_o,
    output logic [3:0]                               bus_be_o,
    output logic [DataWidth-1:0]                     bus_wdata_o,
    input  logic                                     bus_gnt_i,
    input  logic                                     bus_rvalid_i,
    input  logic                                     bus_err_i,
    input  logic [DataWidth-1:0]                     bus_rdata_i,
`ifdef BUS_ARB_PERF_EN
    output logic [NrHosts-1:0][31:0]                 grant_cnt_o,
`endif
    output logic                                     unexp_rsp_o
);

    localparam int unsigned HostW = $clog2(NrHosts);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    logic [HostW-1:0]                       last_q, last_d;
    logic [MaxOutstanding-1:0][HostW-1:0]   fifo_q;
    logic [PtrW-1:0]                        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic                                   unexp_q, unexp_d;

    logic [HostW-1:0] sel;
    logic             sel_valid;
    logic             full;
    logic             push;
    logic             pop;
    logic [HostW-1:0] head;
    int unsigned      idx;

    // Round-robin scan starting just after the last granted host.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= NrHosts; i++) begin
            idx = (32'(last_q) + i) % NrHosts;
            if (!sel_valid && host_req_i[idx[HostW-1:0]]) begin
                sel_valid = 1'b1;
                sel       = idx[HostW-1:0];
            end
        end
    end

    // Full blocks new requests even if a pop happens this cycle: no bypass path.
    assign full      = (cnt_q == CntW'(MaxOutstanding));
    assign bus_req_o = !rst_i && (|host_req_i) && !full;
    assign push      = bus_req_o && bus_gnt_i;
    assign pop       = !rst_i && bus_rvalid_i && (cnt_q != '0);
    assign head      = fifo_q[rptr_q];

    always_comb begin
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        host_gnt_o  = '0;
        if (!rst_i && sel_valid) begin
            bus_we_o    = host_we_i[sel];
            bus_addr_o  = host_addr_i[sel];
            bus_be_o    = host_be_i[sel];
            bus_wdata_o = host_wdata_i[sel];
        end
        if (push) begin
            host_gnt_o[sel] = 1'b1;
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = bus_err_i;
            host_rdata_o[head]  = bus_rdata_i;
        end
    end

    assign unexp_rsp_o = unexp_q && !rst_i;

    always_comb begin
        last_d  = push ? sel : last_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        unexp_d = unexp_q;
        if (push) begin
            wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (bus_rvalid_i && (cnt_q == '0)) begin
            unexp_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= HostW'(NrHosts - 1);
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            unexp_q <= unexp_d;
            if (push) begin
                fifo_q[wptr_q] <= sel;
            end
        end
    end

`ifdef BUS_ARB_PERF_EN
    logic [NrHosts-1:0][31:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                if (host_gnt_o[h] && (perf_q[h] != 32'hFFFF_FFFF)) begin
                    perf_q[h] <= perf_q[h] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt_o = rst_i ? '0 : perf_q;
`endif

endmodule

// File: tb/tb_bus_host_arb.sv
module tb_bus_host_arb;

    localparam int N    = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           host_req, host_we;
    logic [N-1:0][AW-1:0]   host_addr;
    logic [N-1:0][3:0]      host_be;
    logic [N-1:0][DW-1:0]   host_wdata;
    logic [N-1:0]           host_gnt, host_rvalid, host_err;
    logic [N-1:0][DW-1:0]   host_rdata;
    logic                   bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
    logic [AW-1:0]          bus_addr;
    logic [3:0]             bus_be;
    logic [DW-1:0]          bus_wdata, bus_rdata;
    logic                   unexp;
`ifdef BUS_ARB_PERF_EN
    logic [N-1:0][31:0]     grant_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_host_arb #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
        .host_rdata_o(host_rdata),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_be_o(bus_be),
        .bus_wdata_o(bus_wdata),
        .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_err_i(bus_err),
        .bus_rdata_i(bus_rdata),
`ifdef BUS_ARB_PERF_EN
        .grant_cnt_o(grant_cnt),
`endif
        .unexp_rsp_o(unexp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: last granted host, queue of outstanding host ids, sticky flag.
    int m_last = N - 1;
    int m_q[$];
    bit m_unexp = 1'b0;

    always @(negedge clk) begin : cmp
        int                 sel;
        int                 h;
        bit                 hs;
        bit                 popped;
        logic               e_req, e_we;
        logic [AW-1:0]      e_addr;
        logic [3:0]         e_be;
        logic [DW-1:0]      e_wdata;
        logic [N-1:0]       e_gnt, e_rv, e_err;
        logic [N*DW-1:0]    e_rdata;
        logic               e_unexp;

        sel = -1; hs = 1'b0; popped = 1'b0;
        e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
        e_gnt = '0; e_rv = '0; e_err = '0; e_rdata = '0; e_unexp = 1'b0;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                h = (m_last + k) % N;
                if (sel < 0 && host_req[h]) sel = h;
            end
            e_req = (sel >= 0) && (m_q.size() < MAXO);
            if (sel >= 0) begin
                e_we = host_we[sel]; e_addr = host_addr[sel];
                e_be = host_be[sel]; e_wdata = host_wdata[sel];
            end
            hs = e_req && bus_gnt;
            if (hs) e_gnt[sel] = 1'b1;
            if (bus_rvalid && m_q.size() > 0) begin
                popped = 1'b1;
                h = m_q[0];
                e_rv[h] = 1'b1;
                e_err[h] = bus_err;
                e_rdata[h*DW +: DW] = bus_rdata;
            end
            e_unexp = m_unexp;
        end

        chk("bus_req", 64'(bus_req), 64'(e_req));
        chk("bus_we", 64'(bus_we), 64'(e_we));
        chk("bus_addr", 64'(bus_addr), 64'(e_addr));
        chk("bus_be", 64'(bus_be), 64'(e_be));
        chk("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
        chk("host_gnt", 64'(host_gnt), 64'(e_gnt));
        chk("host_rvalid", 64'(host_rvalid), 64'(e_rv));
        chk("host_err", 64'(host_err), 64'(e_err));
        chk("host_rdata", 64'(host_rdata), 64'(e_rdata));
        chk("unexp_rsp", 64'(unexp), 64'(e_unexp));

        if (rst) begin
            m_last = N - 1;
            m_q.delete();
            m_unexp = 1'b0;
        end else begin
            if (bus_rvalid && !popped) m_unexp = 1'b1;
            if (popped) void'(m_q.pop_front());
            if (hs) begin
                m_q.push_back(sel);
                m_last = sel;
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge.
    task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] we,
                        input logic g, input logic rv, input logic [31:0] rd,
                        input logic e);
        @(posedge clk);
        #1;
        rst = r; host_req = rq; host_we = we; bus_gnt = g;
        bus_rvalid = rv; bus_rdata = rd; bus_err = e;
        #1;
    endtask

    initial begin
        rst = 1'b1; host_req = 2'b11; host_we = 2'b00; bus_gnt = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = '0; bus_err = 1'b0;
        host_addr[0] = 32'h0000_0100; host_addr[1] = 32'h0002_0000;
        host_be[0] = 4'hF; host_be[1] = 4'h3;
        host_wdata[0] = 32'hA0A0_A0A0; host_wdata[1] = 32'hB1B1_B1B1;

        // Reset with active inputs: everything held at zero.
        step(1, 2'b11, 2'b00, 1, 1, 32'h5555_5555, 1);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        step(1, 2'b11, 2'b00, 1, 1, 32'h5555_5555, 1);
        chk("rst_gnt", 64'(host_gnt), 64'd0);

        // Both requesting, grant always high: alternation with push+pop at count 1.
        step(0, 2'b11, 2'b00, 1, 0, 32'h0, 0);
        chk("alt_gnt0", 64'(host_gnt), 64'h1);
        step(0, 2'b11, 2'b00, 1, 1, 32'h1111_1111, 0);
        chk("alt_gnt1", 64'(host_gnt), 64'h2);
        chk("alt_rv1", 64'(host_rvalid), 64'h1);
        step(0, 2'b11, 2'b00, 1, 1, 32'h2222_2222, 0);
        chk("alt_gnt2", 64'(host_gnt), 64'h1);
        chk("alt_rv2", 64'(host_rvalid), 64'h2);
        step(0, 2'b11, 2'b00, 1, 1, 32'h3333_3333, 0);
        chk("alt_gnt3", 64'(host_gnt), 64'h2);
        step(0, 2'b00, 2'b00, 1, 1, 32'h4444_4444, 0);
        chk("alt_drain", 64'(host_rvalid), 64'h2);

        // Fill to MaxOutstanding with no responses.
        step(0, 2'b01, 2'b00, 1, 0, 32'h0, 0);
        chk("fill_req0", 64'(bus_req), 64'd1);
        step(0, 2'b01, 2'b00, 1, 0, 32'h0, 0);
        chk("fill_req1", 64'(bus_req), 64'd1);
        step(0, 2'b01, 2'b00, 1, 0, 32'h0, 0);
        chk("full_req2", 64'(bus_req), 64'd0);
        step(0, 2'b01, 2'b00, 1, 0, 32'h0, 0);
        step(0, 2'b01, 2'b00, 1, 1, 32'h6666_6666, 0);
        chk("full_pop_req", 64'(bus_req), 64'd0);
        chk("full_pop_rv", 64'(host_rvalid), 64'h1);
        step(0, 2'b00, 2'b00, 1, 1, 32'h7777_7777, 0);

        // No bus grant: request shown, pointer must not move.
        step(0, 2'b11, 2'b00, 0, 0, 32'h0, 0);
        chk("nogrant_gnt", 64'(host_gnt), 64'd0);
        chk("nogrant_addr", 64'(bus_addr), 64'h2_0000);
        step(0, 2'b11, 2'b00, 0, 0, 32'h0, 0);

        // h1 write then h0 read; responses routed in handshake order.
        step(0, 2'b10, 2'b10, 1, 0, 32'h0, 0);
        chk("wr_gnt", 64'(host_gnt), 64'h2);
        chk("wr_addr", 64'(bus_addr), 64'h2_0000);
        chk("wr_we", 64'(bus_we), 64'd1);
        step(0, 2'b01, 2'b00, 1, 0, 32'h0, 0);
        chk("rd_gnt", 64'(host_gnt), 64'h1);
        step(0, 2'b00, 2'b00, 1, 1, 32'hDEAD_BEEF, 0);
        chk("rsp1_rv", 64'(host_rvalid), 64'h2);
        chk("rsp1_h1", 64'(host_rdata[1]), 64'hDEAD_BEEF);
        chk("rsp1_h0", 64'(host_rdata[0]), 64'd0);
        step(0, 2'b00, 2'b00, 1, 1, 32'h1234_5678, 1);
        chk("rsp2_h0", 64'(host_rdata[0]), 64'h1234_5678);
        chk("rsp2_err", 64'(host_err), 64'h1);

        // Response with nothing outstanding.
        step(0, 2'b00, 2'b00, 1, 1, 32'hCAFE_0000, 0);
        chk("unexp_rv", 64'(host_rvalid), 64'd0);
        step(0, 2'b00, 2'b00, 1, 0, 32'h0, 0);
        chk("unexp_set", 64'(unexp), 64'd1);
        step(0, 2'b00, 2'b00, 1, 0, 32'h0, 0);
        chk("unexp_hold", 64'(unexp), 64'd1);

        // Reset with two outstanding, then a stale response.
        step(0, 2'b11, 2'b00, 1, 0, 32'h0, 0);
        step(0, 2'b11, 2'b00, 1, 0, 32'h0, 0);
        step(1, 2'b11, 2'b00, 1, 1, 32'h0, 0);
        chk("mid_rst_unexp", 64'(unexp), 64'd0);
        step(0, 2'b11, 2'b00, 0, 1, 32'hBAD0_BAD0, 0);
        chk("stale_rv", 64'(host_rvalid), 64'd0);
        chk("post_rst_sel", 64'(bus_addr), 64'h100);
        step(0, 2'b11, 2'b00, 1, 0, 32'h0, 0);
        chk("post_rst_gnt", 64'(host_gnt), 64'h1);
        chk("stale_unexp", 64'(unexp), 64'd1);
        step(0, 2'b00, 2'b00, 1, 1, 32'h0BAD_F00D, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_host_arb.md
BUS_HOST_ARB -- requirements
Module: bus_host_arb

Interface
REQ-001 SHALL have parameter NrHosts, default 2: number of requesting hosts, range 2..4.
REQ-002 SHALL have parameter DataWidth, default 32: data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32: address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2: response-tracking FIFO depth, range 1..4.
REQ-005 SHALL have clk_i  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have rst_i  in  1  reset, synchronous to clk_i, active-high.
REQ-007 SHALL have host_req_i, host_we_i  in  1 per host  request and write-enable per host.
REQ-008 SHALL have host_addr_i  in  AddressWidth per host; host_be_i  in  4 per host; host_wdata_i  in  DataWidth per host.
REQ-009 SHALL have host_gnt_o, host_rvalid_o, host_err_o  out  1 per host; host_rdata_o  out  DataWidth per host.
REQ-010 SHALL have bus_req_o, bus_we_o  out  1; bus_addr_o  out  AddressWidth; bus_be_o  out  4; bus_wdata_o  out  DataWidth: shared downstream bus host port.
REQ-011 SHALL have bus_gnt_i, bus_rvalid_i, bus_err_i  in  1; bus_rdata_i  in  DataWidth.
REQ-012 SHALL have unexp_rsp_o  out  1: sticky flag set by a response that has no outstanding request.

Function
REQ-013 SHALL select one requesting host per cycle, combinationally, using round-robin priority that starts at host (last_ptr+1) mod NrHosts.
REQ-014 SHALL drive bus_req_o = (any host_req_i) AND (fifo_count < MaxOutstanding); when full, bus_req_o SHALL be 0 even if a pop occurs in the same cycle.
REQ-015 SHALL drive bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o from the selected host; when no host is selected, these SHALL be 0.
REQ-016 SHALL assert host_gnt_o[sel] = bus_req_o AND bus_gnt_i, the same cycle, for the selected host only; all other grants SHALL be 0.
REQ-017 SHALL, on handshake (bus_req_o AND bus_gnt_i), set last_ptr to sel and push sel into the response FIFO.
REQ-018 SHALL NOT update last_ptr while there is no handshake; a requester not granted SHALL keep its priority position.
REQ-019 SHALL, on bus_rvalid_i with the FIFO non-empty, pulse host_rvalid_o[head] for one cycle with host_rdata_o[head] = bus_rdata_i and host_err_o[head] = bus_err_i, combinationally, and pop the head.
REQ-020 SHALL drive host_rdata_o = 0 and host_rvalid_o/host_err_o = 0 for non-addressed hosts.
REQ-021 SHALL, on bus_rvalid_i with the FIFO empty, drop the response, assert no host_rvalid_o, and set unexp_rsp_o, which holds until reset.
REQ-022 SHALL support a push and a pop in the same cycle, leaving fifo_count unchanged, with the FIFO read and write pointers wrapping modulo MaxOutstanding.
REQ-023 SHALL deliver responses to hosts in handshake order.

Reset
REQ-024 SHALL, when rst_i is sampled high, set last_ptr = NrHosts-1 (host 0 highest priority), empty the FIFO, and clear unexp_rsp_o.
REQ-025 SHALL hold all outputs at 0 in any cycle where rst_i is high.
REQ-026 SHALL, when reset is asserted mid-transaction, discard outstanding entries; responses arriving after reset SHALL follow REQ-021.

Configuration
REQ-027 SHALL, with BUS_ARB_PERF_EN defined, add output grant_cnt_o (32 bits per host), cleared by reset, incremented on each handshake for that host, and saturating at 0xFFFFFFFF.
REQ-028 SHALL, without BUS_ARB_PERF_EN, omit the grant_cnt_o port and its counters entirely.

Verification
REQ-029 SHALL verify: after reset, host_req_i = 2'b11 with bus_gnt_i = 1 continuously -> grants alternate h0, h1, h0, h1.
REQ-030 SHALL verify: MaxOutstanding = 2, bus_gnt_i = 1, bus_rvalid_i = 0 -> 2 handshakes, then bus_req_o = 0 until an rvalid arrives.
REQ-031 SHALL verify: h1 write addr 0x20000 is granted, then h0 read, then rvalid with rdata 0xDEADBEEF and a second rvalid with 0x12345678 -> h1 receives 0xDEADBEEF, h0 receives 0x12345678.
REQ-032 SHALL verify: bus_rvalid_i pulses with the FIFO empty -> no host_rvalid_o, and unexp_rsp_o = 1 until rst_i.
REQ-033 SHALL verify: push and pop in the same cycle at count 1 -> count remains 1, and ordering is preserved across the pointer wrap.
REQ-034 SHALL verify: rst_i asserted with 2 outstanding -> the FIFO empties, host 0 wins next, and a stale rvalid sets unexp_rsp_o.
